axi4_lite_reg_slave: RTL

AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

---
 rtl/axi4_lite_reg_slave.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave with eight 32-bit registers (REG7 read-only ID).
// Independent write (AW/W/B) and read (AR/R) paths, all outputs registered.
module axi4_lite_reg_slave #(
    parameter logic [31:0] ID_VALUE = 32'hA5A5_0001
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wstate_e     w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic [31:0] regs_q [7];
    logic [31:0] regs_d [7];

    rstate_e     r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_err, rd_err, wr_commit;
    logic [31:0] rd_val;

    // Protection attributes carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    assign aw_hs = awvalid & awready_q;
    assign w_hs  = wvalid & wready_q;
    assign ar_hs = arvalid & arready_q;

    // A channel whose ready is still high has not been latched yet.
    assign eff_addr = awready_q ? awaddr : aw_addr_q;
    assign eff_data = wready_q ? wdata : w_data_q;
    assign eff_strb = wready_q ? wstrb : w_strb_q;

    assign wr_idx = eff_addr[4:2];
    assign wr_err = (|eff_addr[31:5]) | (|eff_addr[1:0])
                  | (wr_idx == 3'd7);

    assign rd_idx = araddr[4:2];
    assign rd_err = (|araddr[31:5]) | (|araddr[1:0]);

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_val = ID_VALUE;
        for (int i = 0; i < 7; i++) begin
            if (rd_idx == 3'(i)) rd_val = regs_q[i];
        end
    end

    // Write FSM next state: latch AW/W, commit when both are held.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        wr_commit = 1'b0;
        for (int i = 0; i < 7; i++) regs_d[i] = regs_q[i];

        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs) aw_addr_d = awaddr;
                if (w_hs) begin
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    awready_d = 1'b0;
                    w_state_d = W_WAIT;
                end else if (w_hs) begin
                    wready_d  = 1'b0;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (aw_hs) aw_addr_d = awaddr;
                if (w_hs) begin
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (aw_hs || w_hs) wr_commit = 1'b1;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (wr_commit) begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
            for (int i = 0; i < 7; i++) begin
                if (!wr_err && wr_idx == 3'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (eff_strb[b])
                            regs_d[i][8*b +: 8] = eff_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read FSM next state: capture data on AR, hold until R accepted.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = rd_err ? 32'd0 : rd_val;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_addr_q <= 32'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            for (int i = 0; i < 7; i++) regs_q[i] <= 32'd0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            for (int i = 0; i < 7; i++) regs_q[i] <= regs_d[i];
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule
